vid_fb: RTL and testbench

- 4096-pixel, 1-bit-per-pixel framebuffer (128x32) feeding the NTSC composite stage.
- Video side takes the 12-bit pixel address driven by the NTSC stage and returns `pix`.
- CPU side gives byte-wide read/write access with a req/ack handshake.
- A built-in fill engine clears or sets the whole buffer. Backing store is one inferred single-port 512x8 RAM shared by all three clients.

---
 rtl/vid_pkg.sv | 22 ++
 rtl/vid_fb_ram.sv | 20 ++
 rtl/vid_fb.sv | 121 ++++++++++++
 tb/tb_vid_fb.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vid_pkg.sv
// Shared framebuffer geometry, arbiter state encoding and pixel-to-byte mapping.
package vid_pkg;

   localparam int unsigned FB_W     = 128;
   localparam int unsigned FB_H     = 32;
   localparam int unsigned FB_PIX   = 4096;
   localparam int unsigned FB_BYTES = 512;
   localparam int unsigned PIX_AW   = 12;
   localparam int unsigned BYTE_AW  = 9;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CPU_RD = 2'd1,
      FILL   = 2'd2
   } fb_state_e;

   // Each byte holds 8 vertically adjacent pixels; the low 3 address bits pick the row.
   function automatic logic [BYTE_AW-1:0] pix_byte(input logic [PIX_AW-1:0] a);
      return a[PIX_AW-1:3];
   endfunction

endpackage

// File: rtl/vid_fb_ram.sv
// Single-port synchronous byte RAM, one-cycle read latency, read-first on write.
module vid_fb_ram #(
   parameter int unsigned NBYTES = 512,
   parameter int unsigned AW     = 9
) (
   input  logic          clk32mhz,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [7:0]    wdata,
   output logic [7:0]    rdata
);

   logic [7:0] mem [NBYTES];

   always_ff @(posedge clk32mhz) begin
      if (we) mem[addr] <= wdata;
      rdata <= mem[addr];
   end

endmodule

// File: rtl/vid_fb.sv
// 128x32 1bpp framebuffer: video fetch, fill engine and CPU port share one RAM.
module vid_fb
   import vid_pkg::*;
#(
   parameter int unsigned NBYTES = FB_BYTES,
   parameter int unsigned AW     = BYTE_AW
) (
   input  logic              clk32mhz,
   input  logic              resetn,
   input  logic [PIX_AW-1:0] adr,
   output logic              pix,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [AW-1:0]     cpu_addr,
   input  logic [7:0]        cpu_wdata,
   output logic [7:0]        cpu_rdata,
   output logic              cpu_ack,
   input  logic              fill_start,
   input  logic              fill_val,
   output logic              fill_busy
);

   fb_state_e         state;
   fb_state_e         state_nx;
   logic [PIX_AW-1:0] last_adr;
   logic              vid_rd_q;
   logic [AW-1:0]     fill_cnt;
   logic              fill_val_q;

   logic              vid_fetch_c;
   logic              cpu_go_c;
   logic              fill_wr_c;
   logic              ram_we_c;
   logic [AW-1:0]     ram_addr_c;
   logic [7:0]        ram_wdata_c;
   logic [7:0]        ram_rdata;

   assign vid_fetch_c = (adr != last_adr);

   always_ff @(posedge clk32mhz or negedge resetn) begin
      if (!resetn) state <= IDLE;
      else         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: begin
            if (fill_start)                state_nx = FILL;
            else if (cpu_go_c && !cpu_we)  state_nx = CPU_RD;
         end
         CPU_RD: state_nx = IDLE;
         FILL: begin
            if (fill_wr_c && (fill_cnt == AW'(NBYTES - 1))) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Port arbitration: video fetch overrides whatever the FSM wanted this cycle.
   always_comb begin
      cpu_go_c    = 1'b0;
      fill_wr_c   = 1'b0;
      ram_addr_c  = cpu_addr;
      ram_wdata_c = cpu_wdata;
      unique case (state)
         IDLE: begin
            // cpu_ack high means the held request was just serviced.
            cpu_go_c = cpu_req && !cpu_ack && !fill_start && !vid_fetch_c;
         end
         FILL: begin
            fill_wr_c   = !vid_fetch_c;
            ram_addr_c  = fill_cnt;
            ram_wdata_c = {8{fill_val_q}};
         end
         default: ;
      endcase
      ram_we_c = fill_wr_c || (cpu_go_c && cpu_we);
      if (vid_fetch_c) ram_addr_c = AW'(pix_byte(adr));
   end

   always_ff @(posedge clk32mhz or negedge resetn) begin
      if (!resetn) begin
         last_adr   <= '1;
         vid_rd_q   <= 1'b0;
         pix        <= 1'b0;
         cpu_rdata  <= 8'h00;
         cpu_ack    <= 1'b0;
         fill_busy  <= 1'b0;
         fill_cnt   <= '0;
         fill_val_q <= 1'b0;
      end else begin
         vid_rd_q <= vid_fetch_c;
         if (vid_fetch_c) last_adr <= adr;
         if (vid_rd_q)    pix <= ram_rdata[last_adr[2:0]];

         cpu_ack <= (cpu_go_c && cpu_we) || (state == CPU_RD);
         if (state == CPU_RD) cpu_rdata <= ram_rdata;

         fill_busy <= (state_nx == FILL);
         if ((state == IDLE) && fill_start) begin
            fill_cnt   <= '0;
            fill_val_q <= fill_val;
         end else if (fill_wr_c && (fill_cnt != AW'(NBYTES - 1))) begin
            fill_cnt <= fill_cnt + AW'(1);
         end
      end
   end

   vid_fb_ram #(
      .NBYTES (NBYTES),
      .AW     (AW)
   ) u_ram (
      .clk32mhz (clk32mhz),
      .we       (ram_we_c),
      .addr     (ram_addr_c),
      .wdata    (ram_wdata_c),
      .rdata    (ram_rdata)
   );

endmodule

// File: tb/tb_vid_fb.sv
// Self-checking bench for vid_fb against a byte-array model of the framebuffer.
module tb_vid_fb;

   logic        clk32mhz = 1'b0;
   logic        resetn;
   logic [11:0] adr;
   logic        pix;
   logic        cpu_req;
   logic        cpu_we;
   logic [8:0]  cpu_addr;
   logic [7:0]  cpu_wdata;
   logic [7:0]  cpu_rdata;
   logic        cpu_ack;
   logic        fill_start;
   logic        fill_val;
   logic        fill_busy;

   int          checks   = 0;
   int          failures = 0;
   logic [7:0]  model [512];
   logic        exp_pix;

   vid_fb dut (
      .clk32mhz   (clk32mhz),
      .resetn     (resetn),
      .adr        (adr),
      .pix        (pix),
      .cpu_req    (cpu_req),
      .cpu_we     (cpu_we),
      .cpu_addr   (cpu_addr),
      .cpu_wdata  (cpu_wdata),
      .cpu_rdata  (cpu_rdata),
      .cpu_ack    (cpu_ack),
      .fill_start (fill_start),
      .fill_val   (fill_val),
      .fill_busy  (fill_busy)
   );

   always #15 clk32mhz = ~clk32mhz;

   function automatic logic model_pix(input logic [11:0] a);
      logic [7:0] b;
      b = model[a[11:3]];
      return b[a[2:0]];
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic model_fill(input logic v);
      for (int i = 0; i < 512; i++) model[i] = {8{v}};
   endtask

   // Called at a negedge; returns read data and cycles until ack was seen.
   task automatic cpu_op(input logic we, input logic [8:0] a, input logic [7:0] wd,
                         output logic [7:0] rd, output int lat);
      cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd; lat = 0;
      do begin
         @(negedge clk32mhz);
         lat++;
      end while (!cpu_ack && lat < 8);
      chk("cpu_ack_seen", 32'(cpu_ack), 32'd1);
      rd = cpu_rdata;
      if (we && cpu_ack) model[a] = wd;
      cpu_req = 1'b0; cpu_we = 1'b0;
      @(negedge clk32mhz);
      chk("ack_one_cycle", 32'(cpu_ack), 32'd0);
   endtask

   task automatic step_adr(input logic [11:0] a, input int hold, input logic chk_old);
      logic old_v;
      logic new_v;
      old_v = exp_pix;
      new_v = model_pix(a);
      adr = a;
      @(negedge clk32mhz);
      if (chk_old) chk("pix_hold_1clk", 32'(pix), 32'(old_v));
      @(negedge clk32mhz);
      chk("pix_2clk", 32'(pix), 32'(new_v));
      exp_pix = new_v;
      for (int k = 2; k < hold; k++) begin
         @(negedge clk32mhz);
         chk("pix_stable", 32'(pix), 32'(new_v));
      end
   endtask

   task automatic do_fill(input logic v, output int n);
      fill_start = 1'b1; fill_val = v;
      @(negedge clk32mhz);
      fill_start = 1'b0;
      n = 0;
      while (fill_busy === 1'b1 && n < 2000) begin
         n++;
         @(negedge clk32mhz);
      end
      model_fill(v);
   endtask

   initial begin
      logic [7:0]  rd;
      logic [11:0] a;
      logic        snap;
      logic        op_we;
      logic [8:0]  op_a;
      logic [7:0]  op_d;
      int          lat, n, acks, chg_cyc, start, w;
      bit          active;

      resetn = 1'b0; adr = 12'hFFF; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0;
      cpu_wdata = '0; fill_start = 1'b0; fill_val = 1'b0; exp_pix = 1'b0;
      repeat (3) @(negedge clk32mhz);
      chk("rst_pix", 32'(pix), 32'd0);
      chk("rst_rdata", 32'(cpu_rdata), 32'd0);
      chk("rst_ack", 32'(cpu_ack), 32'd0);
      chk("rst_busy", 32'(fill_busy), 32'd0);
      resetn = 1'b1;
      @(negedge clk32mhz);

      // Known contents: clear everything.
      do_fill(1'b0, n);
      chk("fill0_cycles", 32'(n), 32'd512);

      // Column pattern 0x81 in byte 5 -> pixels 40..47.
      cpu_op(1'b1, 9'd5, 8'h81, rd, lat);
      chk("wr_latency", 32'(lat), 32'd1);
      for (int i = 40; i < 48; i++) step_adr(12'(i), 5, 1'b1);

      cpu_op(1'b1, 9'd300, 8'hA5, rd, lat);
      cpu_op(1'b0, 9'd300, 8'h00, rd, lat);
      chk("rd300", 32'(rd), 32'h0A5);
      chk("rd_latency", 32'(lat), 32'd2);
      cpu_op(1'b0, 9'd301, 8'h00, rd, lat);
      chk("rd301_fill", 32'(rd), 32'(model[301]));

      // fill_start and a CPU read arrive together: fill wins, read waits.
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 9'd511;
      fill_start = 1'b1; fill_val = 1'b1;
      @(negedge clk32mhz);
      fill_start = 1'b0;
      n = 0; acks = 0;
      while (fill_busy === 1'b1 && n < 2000) begin
         n++;
         if (cpu_ack) acks++;
         @(negedge clk32mhz);
      end
      model_fill(1'b1);
      chk("fill1_cycles", 32'(n), 32'd512);
      chk("no_ack_in_fill", 32'(acks), 32'd0);
      lat = 0;
      while (!cpu_ack && lat < 8) begin
         @(negedge clk32mhz);
         lat++;
      end
      chk("ack_after_fill", 32'(cpu_ack), 32'd1);
      chk("rd511_after_fill", 32'(cpu_rdata), 32'h0FF);
      cpu_req = 1'b0;
      @(negedge clk32mhz);

      for (int i = 0; i < 64; i++) begin
         do a = 12'($urandom); while (a == adr);
         step_adr(a, 3, 1'b1);
      end
      cpu_op(1'b0, 9'd511, 8'h00, rd, lat);
      chk("rd511", 32'(rd), 32'h0FF);

      // Pixel address changes every 5 clocks while CPU traffic is held.
      chg_cyc = -100; active = 1'b0; start = 0; snap = exp_pix;
      op_we = 1'b0; op_a = '0; op_d = '0;
      for (int c = 0; c < 400; c++) begin
         if (c == chg_cyc + 2) exp_pix = snap;
         chk("tog_pix", 32'(pix), 32'(exp_pix));
         if (active) begin
            if (cpu_ack) begin
               chk("tog_ack_lat", 32'((c - start) <= 5), 32'd1);
               if (op_we) model[op_a] = op_d;
               else       chk("tog_rdata", 32'(cpu_rdata), 32'(model[op_a]));
               cpu_req = 1'b0; active = 1'b0;
            end else if (c - start >= 5) begin
               chk("tog_ack_timeout", 32'(cpu_ack), 32'd1);
               cpu_req = 1'b0; active = 1'b0;
            end
         end else if (c % 3 == 1) begin
            op_we = 1'($urandom); op_a = 9'($urandom); op_d = 8'($urandom);
            cpu_req = 1'b1; cpu_we = op_we; cpu_addr = op_a; cpu_wdata = op_d;
            start = c; active = 1'b1;
         end
         if (c % 5 == 0) begin
            do a = 12'($urandom); while (a == adr);
            adr = a;
            snap = model_pix(a);
            chg_cyc = c;
         end
         @(negedge clk32mhz);
      end
      w = 0;
      while (active && !cpu_ack && w < 8) begin
         @(negedge clk32mhz);
         w++;
      end
      if (active) begin
         chk("tog_drain_ack", 32'(cpu_ack), 32'd1);
         if (cpu_ack && op_we) model[op_a] = op_d;
         cpu_req = 1'b0;
      end
      repeat (3) @(negedge clk32mhz);
      exp_pix = snap;
      chk("tog_final_pix", 32'(pix), 32'(exp_pix));

      // Video fetches during a fill stretch it beyond 512 cycles.
      fill_start = 1'b1; fill_val = 1'b0;
      @(negedge clk32mhz);
      fill_start = 1'b0;
      n = 0;
      while (fill_busy === 1'b1 && n < 2000) begin
         n++;
         if (n % 5 == 0) begin
            do a = 12'($urandom); while (a == adr);
            adr = a;
         end
         @(negedge clk32mhz);
      end
      model_fill(1'b0);
      chk("fill_stretched", 32'(n > 512), 32'd1);
      chk("fill_stretch_bound", 32'(n <= 512 + n / 5 + 2), 32'd1);
      do a = 12'($urandom); while (a == adr);
      step_adr(a, 3, 1'b0);
      for (int i = 0; i < 8; i++) begin
         do a = 12'($urandom); while (a == adr);
         step_adr(a, 3, 1'b1);
      end
      cpu_op(1'b0, 9'($urandom), 8'h00, rd, lat);
      chk("rd_after_fill0", 32'(rd), 32'h000);

      // Reset in the middle of a fill.
      cpu_op(1'b1, 9'd400, 8'hFF, rd, lat);
      step_adr(12'(400 * 8 + 2), 3, 1'b1);
      chk("pix_b400", 32'(pix), 32'd1);
      fill_start = 1'b1; fill_val = 1'b0;
      @(negedge clk32mhz);
      fill_start = 1'b0;
      repeat (99) @(negedge clk32mhz);
      chk("busy_before_rst", 32'(fill_busy), 32'd1);
      #2 resetn = 1'b0;
      #1;
      chk("rst_mid_busy", 32'(fill_busy), 32'd0);
      chk("rst_mid_ack", 32'(cpu_ack), 32'd0);
      chk("rst_mid_pix", 32'(pix), 32'd0);
      @(negedge clk32mhz);
      @(negedge clk32mhz);
      resetn = 1'b1;
      exp_pix = 1'b0;
      @(negedge clk32mhz);
      chk("post_rst_pix_old", 32'(pix), 32'd0);
      @(negedge clk32mhz);
      chk("post_rst_pix_ram_kept", 32'(pix), 32'(model_pix(adr)));
      exp_pix = model_pix(adr);

      do_fill(1'b1, n);
      chk("refill_cycles", 32'(n), 32'd512);
      cpu_op(1'b0, 9'd0, 8'h00, rd, lat);
      chk("refill_rd0", 32'(rd), 32'h0FF);
      cpu_op(1'b0, 9'd200, 8'h00, rd, lat);
      chk("refill_rd200", 32'(rd), 32'h0FF);
      for (int i = 0; i < 4; i++) begin
         do a = 12'($urandom); while (a == adr);
         step_adr(a, 3, 1'b1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
